ram_writer_ctrl: RTL and testbench
==================================

RAM_WRITER_CTRL -- requirements
Module: ram_writer_ctrl

Interface
- REQ-001 SHALL have parameter BASE_ADDR, default 32'h1E00_0000, byte address of ring-buffer slot 0.
- REQ-002 SHALL have parameter MAX_LOG_LENGTH, default 20, upper clamp for log_length.
- REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic on rising edge.
- REQ-004 SHALL have port areset, input, 1 bit: reset, synchronous, active-high.
- REQ-005 SHALL have port GPIO, input, 32 bits: [0] enable, [1] request, [6:2] log_length, [11:7] log_throttle, [31:12] ignored.
- REQ-006 SHALL have ports S_AXIS_tvalid (input, 1), S_AXIS_tdata (input, 32) and S_AXIS_tready (output, 1): the sample stream.
- REQ-007 SHALL have ports wr_valid (output, 1), wr_addr (output, 32), wr_data (output, 32) and wr_ready (input, 1): the write command to the RAM writer.
- REQ-008 SHALL have ports position (output, 32), next slot index, and done (output, 1), capture frozen.
- REQ-009 SHALL have port overrun_cnt, output, 16 bits, see Configuration.

Function
- REQ-010 SHALL implement states IDLE, RUN, POST, HOLD and DRAIN.
- REQ-011 In IDLE, when enable=1: latch L=min(log_length,MAX_LOG_LENGTH) and T=log_throttle, clear wr_ptr and the throttle counter, go to RUN; the latched values are used until the next IDLE exit.
- REQ-012 S_AXIS_tready SHALL be 1 only in RUN or POST, and only when !wr_valid || wr_ready.
- REQ-013 Each accepted beat (tvalid&&tready) SHALL increment the throttle counter modulo 2^T; a beat is kept only when the counter is 0 before the increment.
- REQ-014 A kept beat SHALL assert wr_valid on the next cycle, with wr_data=tdata and wr_addr=BASE_ADDR+(wr_ptr<<2).
- REQ-015 wr_valid, wr_addr and wr_data SHALL hold stable until wr_valid&&wr_ready.
- REQ-016 On the write handshake, wr_ptr SHALL become (wr_ptr+1) mod 2^L, and position SHALL take the new wr_ptr in the same edge.
- REQ-017 A request rising edge (0->1 between consecutive cycles) in RUN SHALL load post_cnt=2^L>>1 and go to POST; in any other state it is ignored.
- REQ-018 In POST, each completed write SHALL decrement post_cnt; at 0 with no write outstanding, go to HOLD; if post_cnt=0 on entry (L=0), go to HOLD on the next cycle.
- REQ-019 In HOLD, done=1 and no beats are accepted; request=0 returns to RUN without reinitialising wr_ptr.
- REQ-020 enable=0 in RUN, POST or HOLD SHALL go to IDLE next cycle if wr_valid=0, else to DRAIN.
- REQ-021 DRAIN SHALL keep wr_valid until the handshake, then go to IDLE; tready=0 throughout DRAIN.
- REQ-022 If a request edge and enable=0 occur in the same cycle, the enable=0 transition (REQ-020) SHALL take priority.
- REQ-023 With wr_ready held 1, the throughput SHALL be one kept beat per cycle.

Reset
- REQ-024 areset SHALL force IDLE, wr_valid=0, wr_addr=BASE_ADDR, wr_data=0, position=0, done=0, tready=0, overrun_cnt=0, and clear the counters and the request edge history; it takes effect mid-transaction, and an outstanding write is dropped.

Configuration
- REQ-025 With RAM_WRITER_CTRL_OVERRUN_EN defined, overrun_cnt SHALL count cycles with tvalid=1 and tready=0 in RUN or POST, saturating at 16'hFFFF and cleared on the IDLE->RUN transition.
- REQ-026 Without RAM_WRITER_CTRL_OVERRUN_EN, overrun_cnt SHALL be constant 0 and no counter logic shall exist.

Structure
- REQ-027 Package ram_writer_pkg SHALL hold the state enum, the GPIO bit-position constants and the clamp helper.
- REQ-028 The throttle counter SHALL be sub-module ram_writer_throttle (inputs T, beat strobe, clear; output keep).

Verification
- REQ-029 GPIO=0x099 (L=6, T=1), tvalid=1, incrementing tdata, wr_ready=1 -> every second beat written; wr_addr walks 0x1E00_0000..0x1E00_00FC and wraps; position cycles 0..63.
- REQ-030 L=6, T=0, request 0->1 -> exactly 32 further writes, then done=1 and tready=0; request->0 -> writes resume at position 32.
- REQ-031 wr_ready=0 for 10 cycles during RUN -> wr_valid/addr/data stable, tready=0; with the macro, overrun_cnt=10.
- REQ-032 enable->0 while wr_valid=1, wr_ready=0 -> DRAIN; after wr_ready=1, one handshake, then IDLE with tready=0.
- REQ-033 GPIO log_length=31 -> L clamped to 20, wrap at slot 1048575->0; log_length=0 with request -> HOLD after 0 post writes.
- REQ-034 areset asserted in POST with wr_valid=1 -> next cycle all outputs at reset values; enable still 1 -> RUN from wr_ptr 0.

Source files
------------

// File: rtl/ram_writer_pkg.sv
// Shared definitions for the ring-buffer RAM writer controller.
//   state_t      : controller states
//   GPIO_*       : bit positions of the control fields inside the GPIO word
//   clamp_len()  : limits the requested log2 ring length to the build maximum
package ram_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_POST  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam int GPIO_ENABLE_BIT  = 0;
    localparam int GPIO_REQUEST_BIT = 1;
    localparam int GPIO_LEN_LSB     = 2;
    localparam int GPIO_LEN_MSB     = 6;
    localparam int GPIO_THR_LSB     = 7;
    localparam int GPIO_THR_MSB     = 11;

    function automatic logic [4:0] clamp_len(input logic [4:0] len, input logic [4:0] max_len);
        if (len > max_len) begin
            clamp_len = max_len;
        end else begin
            clamp_len = len;
        end
    endfunction

endpackage

// File: rtl/ram_writer_throttle.sv
// Beat decimator: keeps one accepted beat out of every 2^throttle_log.
//   clk, rst        : clock and synchronous active-high reset
//   throttle_log    : log2 of the decimation ratio
//   beat            : an input beat is being accepted this cycle
//   clear           : restart the count (next beat is kept)
//   keep            : the beat accepted this cycle is to be kept
module ram_writer_throttle (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] throttle_log,
    input  logic       beat,
    input  logic       clear,
    output logic       keep
);

    logic [31:0] cnt_r;
    logic [31:0] mask_s;

    assign mask_s = (32'd1 << throttle_log) - 32'd1;
    assign keep   = (cnt_r == 32'd0);

    // Beat counter, wrapping modulo 2^throttle_log.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 32'd0;
        end else if (clear) begin
            cnt_r <= 32'd0;
        end else if (beat) begin
            cnt_r <= (cnt_r + 32'd1) & mask_s;
        end
    end

endmodule

// File: rtl/ram_writer_ctrl.sv
// Ring-buffer capture controller: turns a sample stream into RAM write
// commands at BASE_ADDR + 4*slot, with a post-trigger window that freezes
// the capture after half a ring of further writes.
//   aclk, areset                  : clock, synchronous active-high reset
//   GPIO                          : [0] enable, [1] request, [6:2] log length, [11:7] log throttle
//   S_AXIS_tvalid/tdata/tready    : sample stream in
//   wr_valid/addr/data, wr_ready  : write command out
//   position                      : next slot index
//   done                          : capture frozen (HOLD)
//   overrun_cnt                   : stalled-sample cycles, only when
//                                   RAM_WRITER_CTRL_OVERRUN_EN is defined, else 0
module ram_writer_ctrl
    import ram_writer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h1E00_0000,
    parameter int          MAX_LOG_LENGTH = 20
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] GPIO,
    input  logic        S_AXIS_tvalid,
    input  logic [31:0] S_AXIS_tdata,
    output logic        S_AXIS_tready,
    output logic        wr_valid,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    input  logic        wr_ready,
    output logic [31:0] position,
    output logic        done,
    output logic [15:0] overrun_cnt
);

    state_t      state_r, state_s;
    logic [4:0]  len_r, thr_r;
    logic [31:0] wr_ptr_r, ptr_mask_s, ptr_next_s;
    logic [31:0] post_cnt_r, post_cnt_s, post_dec_s;
    logic        req_prev_r;
    logic        wr_valid_r, done_r;
    logic [31:0] wr_addr_r, wr_data_r;
    logic        enable_s, request_s, req_rise_s, start_s;
    logic        active_s, post_room_s, tready_s, beat_s, keep_s, kept_s;
    logic        wr_hs_s, wr_valid_s;
    logic        unused_gpio_s;

    assign enable_s      = GPIO[GPIO_ENABLE_BIT];
    assign request_s     = GPIO[GPIO_REQUEST_BIT];
    assign req_rise_s    = request_s && !req_prev_r;
    assign start_s       = (state_r == ST_IDLE) && enable_s;
    assign unused_gpio_s = ^GPIO[31:12];

    assign active_s    = (state_r == ST_RUN) || (state_r == ST_POST);
    // In POST, stop taking beats once the outstanding write already covers the
    // remaining window, so exactly 2^L/2 writes complete before freezing.
    assign post_room_s = (state_r != ST_POST) || (post_cnt_r > {31'd0, wr_valid_r});
    assign tready_s    = active_s && post_room_s && (!wr_valid_r || wr_ready);
    assign beat_s      = S_AXIS_tvalid && tready_s;
    assign kept_s      = beat_s && keep_s;
    assign wr_hs_s     = wr_valid_r && wr_ready;
    assign wr_valid_s  = kept_s || (wr_valid_r && !wr_ready);

    // A write completing this cycle advances the slot that a new beat lands in.
    assign ptr_mask_s = (32'd1 << len_r) - 32'd1;
    assign ptr_next_s = wr_hs_s ? ((wr_ptr_r + 32'd1) & ptr_mask_s) : wr_ptr_r;
    assign post_dec_s = (wr_hs_s && (post_cnt_r != 32'd0)) ? (post_cnt_r - 32'd1) : post_cnt_r;

    ram_writer_throttle u_throttle (
        .clk          (aclk),
        .rst          (areset),
        .throttle_log (thr_r),
        .beat         (beat_s),
        .clear        (start_s),
        .keep         (keep_s)
    );

    // Next-state and post-trigger window countdown; disable beats a request edge.
    always_comb begin
        state_s    = state_r;
        post_cnt_s = post_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (enable_s) state_s = ST_RUN;
                else          state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!enable_s) begin
                    state_s = wr_valid_s ? ST_DRAIN : ST_IDLE;
                end else if (req_rise_s) begin
                    state_s    = ST_POST;
                    post_cnt_s = (32'd1 << len_r) >> 1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_POST: begin
                post_cnt_s = post_dec_s;
                if (!enable_s)                                    state_s = wr_valid_s ? ST_DRAIN : ST_IDLE;
                else if ((post_dec_s == 32'd0) && !wr_valid_s)    state_s = ST_HOLD;
                else                                              state_s = ST_POST;
            end
            ST_HOLD: begin
                if (!enable_s)       state_s = wr_valid_s ? ST_DRAIN : ST_IDLE;
                else if (!request_s) state_s = ST_RUN;
                else                 state_s = ST_HOLD;
            end
            ST_DRAIN: begin
                if (!wr_valid_s) state_s = ST_IDLE;
                else             state_s = ST_DRAIN;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control state, latched configuration, slot pointer and request history.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r    <= ST_IDLE;
            len_r      <= 5'd0;
            thr_r      <= 5'd0;
            wr_ptr_r   <= 32'd0;
            post_cnt_r <= 32'd0;
            req_prev_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            post_cnt_r <= post_cnt_s;
            req_prev_r <= request_s;
            done_r     <= (state_s == ST_HOLD);
            if (start_s) begin
                len_r    <= clamp_len(GPIO[GPIO_LEN_MSB:GPIO_LEN_LSB], 5'(MAX_LOG_LENGTH));
                thr_r    <= GPIO[GPIO_THR_MSB:GPIO_THR_LSB];
                wr_ptr_r <= 32'd0;
            end else begin
                wr_ptr_r <= ptr_next_s;
            end
        end
    end

    // Write command register; contents only change when a kept beat loads it.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_valid_r <= 1'b0;
            wr_addr_r  <= BASE_ADDR;
            wr_data_r  <= 32'd0;
        end else begin
            wr_valid_r <= wr_valid_s;
            if (kept_s) begin
                wr_data_r <= S_AXIS_tdata;
                wr_addr_r <= BASE_ADDR + (ptr_next_s << 2);
            end
        end
    end

`ifdef RAM_WRITER_CTRL_OVERRUN_EN
    logic [15:0] overrun_r;

    // Saturating count of cycles where a sample is offered but refused.
    always_ff @(posedge aclk) begin
        if (areset) begin
            overrun_r <= 16'd0;
        end else if (start_s) begin
            overrun_r <= 16'd0;
        end else if (active_s && S_AXIS_tvalid && !tready_s && (overrun_r != 16'hFFFF)) begin
            overrun_r <= overrun_r + 16'd1;
        end
    end

    assign overrun_cnt = overrun_r;
`else
    assign overrun_cnt = 16'd0;
`endif

    assign S_AXIS_tready = tready_s;
    assign wr_valid      = wr_valid_r;
    assign wr_addr       = wr_addr_r;
    assign wr_data       = wr_data_r;
    assign position      = wr_ptr_r;
    assign done          = done_r;

endmodule

// File: tb/tb_ram_writer_ctrl.sv
// Self-checking bench for ram_writer_ctrl. A second instance with a small
// length clamp makes the clamp observable within a short run.
module tb_ram_writer_ctrl;

    localparam logic [31:0] BASE = 32'h1E00_0000;

    logic        aclk;
    logic        areset;
    logic [31:0] gpio;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tready;
    logic        wr_valid;
    logic [31:0] wr_addr, wr_data;
    logic        wr_ready;
    logic [31:0] position;
    logic        done;
    logic [15:0] overrun_cnt;

    logic        s_tready, s_wr_valid, s_done;
    logic [31:0] s_wr_addr, s_wr_data, s_position;
    logic [15:0] s_overrun;

    int total = 0;
    int bad   = 0;
    int acc_count = 0;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];

    ram_writer_ctrl dut (
        .aclk(aclk), .areset(areset), .GPIO(gpio),
        .S_AXIS_tvalid(tvalid), .S_AXIS_tdata(tdata), .S_AXIS_tready(tready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .position(position), .done(done), .overrun_cnt(overrun_cnt)
    );

    ram_writer_ctrl #(.BASE_ADDR(BASE), .MAX_LOG_LENGTH(3)) dut_small (
        .aclk(aclk), .areset(areset), .GPIO(gpio),
        .S_AXIS_tvalid(tvalid), .S_AXIS_tdata(tdata), .S_AXIS_tready(s_tready),
        .wr_valid(s_wr_valid), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_ready(wr_ready),
        .position(s_position), .done(s_done), .overrun_cnt(s_overrun)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // One clock: record handshakes seen before the edge, advance the source after it.
    task automatic tick();
        logic acc, hs;
        #1;
        acc = tvalid && tready;
        hs  = wr_valid && wr_ready;
        if (hs) begin
            obs_addr.push_back(wr_addr);
            obs_data.push_back(wr_data);
        end
        @(posedge aclk);
        @(negedge aclk);
        if (acc) begin
            tdata     = tdata + 32'd1;
            acc_count = acc_count + 1;
        end
    endtask

    task automatic go_idle();
        gpio = 32'd0; tvalid = 1'b0; wr_ready = 1'b1;
        repeat (4) tick();
        obs_addr.delete(); obs_data.delete();
        acc_count = 0;
    endtask

    task automatic test_reset();
        areset = 1'b1; tvalid = 1'b1; gpio = 32'h19;
        repeat (3) tick();
        total++; if (wr_valid !== 1'b0)   begin bad++; $display("FAIL reset_wr_valid: got %0b want 0", wr_valid); end
        total++; if (wr_addr !== BASE)    begin bad++; $display("FAIL reset_wr_addr: got %h want %h", wr_addr, BASE); end
        total++; if (wr_data !== 32'd0)   begin bad++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        total++; if (position !== 32'd0)  begin bad++; $display("FAIL reset_position: got %0d want 0", position); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
        total++; if (tready !== 1'b0)     begin bad++; $display("FAIL reset_tready: got %0b want 0", tready); end
        total++; if (overrun_cnt !== 16'd0) begin bad++; $display("FAIL reset_overrun: got %0d want 0", overrun_cnt); end
        areset = 1'b0; tvalid = 1'b0; gpio = 32'd0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d0;
        go_idle();
        gpio = 32'h19; tvalid = 1'b1; wr_ready = 1'b1; d0 = tdata;
        repeat (50) tick();
        total++; if (obs_data.size() !== 48) begin bad++; $display("FAIL b2b_count: got %0d want 48", obs_data.size()); end
        for (int k = 0; k < obs_data.size(); k++) begin
            total++; if (obs_data[k] !== d0 + 32'(k)) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", k, obs_data[k], d0 + 32'(k)); end
            total++; if (obs_addr[k] !== BASE + 32'(k * 4)) begin bad++; $display("FAIL b2b_addr[%0d]: got %h want %h", k, obs_addr[k], BASE + 32'(k * 4)); end
        end
    endtask

    task automatic test_throttle();
        logic [31:0] d0;
        go_idle();
        gpio = 32'h099; tvalid = 1'b1; wr_ready = 1'b1; d0 = tdata;
        repeat (300) tick();
        tvalid = 1'b0;
        repeat (3) tick();
        total++; if (obs_data.size() !== 150) begin bad++; $display("FAIL thr_count: got %0d want 150", obs_data.size()); end
        for (int k = 0; k < obs_data.size(); k++) begin
            total++; if (obs_data[k] !== d0 + 32'(2 * k)) begin bad++; $display("FAIL thr_data[%0d]: got %h want %h", k, obs_data[k], d0 + 32'(2 * k)); end
            total++; if (obs_addr[k] !== BASE + 32'((k % 64) * 4)) begin bad++; $display("FAIL thr_addr[%0d]: got %h want %h", k, obs_addr[k], BASE + 32'((k % 64) * 4)); end
        end
        total++; if (position !== 32'd22) begin bad++; $display("FAIL thr_position: got %0d want 22", position); end
    endtask

    task automatic test_post_hold();
        logic [31:0] d0;
        go_idle();
        gpio = 32'h19; tvalid = 1'b0; wr_ready = 1'b1;
        repeat (2) tick();
        gpio = 32'h1B;
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL post_done_early: got %0b want 0", done); end
        tvalid = 1'b1; d0 = tdata;
        repeat (60) tick();
        total++; if (obs_data.size() !== 32) begin bad++; $display("FAIL post_count: got %0d want 32", obs_data.size()); end
        total++; if (done !== 1'b1)         begin bad++; $display("FAIL hold_done: got %0b want 1", done); end
        total++; if (tready !== 1'b0)       begin bad++; $display("FAIL hold_tready: got %0b want 0", tready); end
        total++; if (position !== 32'd32)   begin bad++; $display("FAIL hold_position: got %0d want 32", position); end
        for (int k = 0; k < obs_data.size(); k++) begin
            total++; if (obs_data[k] !== d0 + 32'(k)) begin bad++; $display("FAIL post_data[%0d]: got %h want %h", k, obs_data[k], d0 + 32'(k)); end
            total++; if (obs_addr[k] !== BASE + 32'(k * 4)) begin bad++; $display("FAIL post_addr[%0d]: got %h want %h", k, obs_addr[k], BASE + 32'(k * 4)); end
        end
        gpio = 32'h19;
        repeat (12) tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL resume_done: got %0b want 0", done); end
        total++; if (obs_data.size() <= 32) begin bad++; $display("FAIL resume_count: got %0d want >32", obs_data.size()); end
        if (obs_data.size() > 32) begin
            total++; if (obs_addr[32] !== BASE + 32'd128) begin bad++; $display("FAIL resume_addr: got %h want %h", obs_addr[32], BASE + 32'd128); end
            total++; if (obs_data[32] !== d0 + 32'd32)   begin bad++; $display("FAIL resume_data: got %h want %h", obs_data[32], d0 + 32'd32); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] d0, sa, sd;
        logic        sv;
        logic [15:0] exp_ovr;
        go_idle();
        gpio = 32'h19; tvalid = 1'b1; wr_ready = 1'b1; d0 = tdata;
        repeat (6) tick();
        wr_ready = 1'b0;
        sv = wr_valid; sa = wr_addr; sd = wr_data;
        total++; if (sv !== 1'b1)           begin bad++; $display("FAIL stall_pre_valid: got %0b want 1", sv); end
        total++; if (sd !== d0 + 32'd4)      begin bad++; $display("FAIL stall_pre_data: got %h want %h", sd, d0 + 32'd4); end
        total++; if (sa !== BASE + 32'd16)   begin bad++; $display("FAIL stall_pre_addr: got %h want %h", sa, BASE + 32'd16); end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (wr_valid !== sv) begin bad++; $display("FAIL stall_valid[%0d]: got %0b want %0b", i, wr_valid, sv); end
            total++; if (wr_addr !== sa)  begin bad++; $display("FAIL stall_addr[%0d]: got %h want %h", i, wr_addr, sa); end
            total++; if (wr_data !== sd)  begin bad++; $display("FAIL stall_data[%0d]: got %h want %h", i, wr_data, sd); end
            total++; if (tready !== 1'b0) begin bad++; $display("FAIL stall_tready[%0d]: got %0b want 0", i, tready); end
        end
`ifdef RAM_WRITER_CTRL_OVERRUN_EN
        exp_ovr = 16'd10;
`else
        exp_ovr = 16'd0;
`endif
        total++; if (overrun_cnt !== exp_ovr) begin bad++; $display("FAIL stall_overrun: got %0d want %0d", overrun_cnt, exp_ovr); end
        wr_ready = 1'b1;
        repeat (5) tick();
        tvalid = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < obs_data.size(); k++) begin
            total++; if (obs_data[k] !== d0 + 32'(k)) begin bad++; $display("FAIL stall_seq_data[%0d]: got %h want %h", k, obs_data[k], d0 + 32'(k)); end
            total++; if (obs_addr[k] !== BASE + 32'(k * 4)) begin bad++; $display("FAIL stall_seq_addr[%0d]: got %h want %h", k, obs_addr[k], BASE + 32'(k * 4)); end
        end
    endtask

    task automatic test_drain();
        logic [31:0] d0;
        go_idle();
        gpio = 32'h19; tvalid = 1'b1; wr_ready = 1'b1; d0 = tdata;
        repeat (5) tick();
        wr_ready = 1'b0;
        tick();
        gpio = 32'd0;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d]: got %0b want 1", i, wr_valid); end
            total++; if (tready !== 1'b0)   begin bad++; $display("FAIL drain_tready[%0d]: got %0b want 0", i, tready); end
            tick();
        end
        total++; if (obs_data.size() !== 3) begin bad++; $display("FAIL drain_pre_count: got %0d want 3", obs_data.size()); end
        wr_ready = 1'b1;
        repeat (4) tick();
        total++; if (obs_data.size() !== 4) begin bad++; $display("FAIL drain_count: got %0d want 4", obs_data.size()); end
        total++; if (wr_valid !== 1'b0)     begin bad++; $display("FAIL drain_end_valid: got %0b want 0", wr_valid); end
        total++; if (tready !== 1'b0)       begin bad++; $display("FAIL drain_end_tready: got %0b want 0", tready); end
        for (int k = 0; k < obs_data.size(); k++) begin
            total++; if (obs_data[k] !== d0 + 32'(k)) begin bad++; $display("FAIL drain_data[%0d]: got %h want %h", k, obs_data[k], d0 + 32'(k)); end
        end
        gpio = 32'h19;
        tick();
        total++; if (position !== 32'd0) begin bad++; $display("FAIL reenable_position: got %0d want 0", position); end
    endtask

    task automatic test_clamp();
        logic [31:0] d0;
        int scnt;
        go_idle();
        gpio = 32'h7D; tvalid = 1'b1; wr_ready = 1'b1; d0 = tdata; scnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (s_wr_valid) begin
                total++; if (s_wr_addr !== BASE + 32'((scnt % 8) * 4)) begin bad++; $display("FAIL clamp_small_addr[%0d]: got %h want %h", scnt, s_wr_addr, BASE + 32'((scnt % 8) * 4)); end
                total++; if (s_wr_data !== d0 + 32'(scnt)) begin bad++; $display("FAIL clamp_small_data[%0d]: got %h want %h", scnt, s_wr_data, d0 + 32'(scnt)); end
                scnt++;
            end
            tick();
        end
        total++; if (scnt !== 58)               begin bad++; $display("FAIL clamp_small_count: got %0d want 58", scnt); end
        total++; if (s_position !== 32'd2)      begin bad++; $display("FAIL clamp_small_position: got %0d want 2", s_position); end
        total++; if (s_done !== 1'b0)           begin bad++; $display("FAIL clamp_small_done: got %0b want 0", s_done); end
        total++; if (s_tready !== 1'b1)         begin bad++; $display("FAIL clamp_small_tready: got %0b want 1", s_tready); end
        total++; if (s_overrun !== 16'd0)       begin bad++; $display("FAIL clamp_small_overrun: got %0d want 0", s_overrun); end
        total++; if (obs_data.size() !== 58)    begin bad++; $display("FAIL clamp_count: got %0d want 58", obs_data.size()); end
        for (int k = 0; k < obs_addr.size(); k++) begin
            total++; if (obs_addr[k] !== BASE + 32'(k * 4)) begin bad++; $display("FAIL clamp_addr[%0d]: got %h want %h", k, obs_addr[k], BASE + 32'(k * 4)); end
        end
    endtask

    task automatic test_log_zero();
        go_idle();
        gpio = 32'h1; tvalid = 1'b0; wr_ready = 1'b1;
        repeat (2) tick();
        gpio = 32'h3;
        tick();
        tvalid = 1'b1;
        tick();
        total++; if (done !== 1'b1)          begin bad++; $display("FAIL l0_done: got %0b want 1", done); end
        total++; if (tready !== 1'b0)        begin bad++; $display("FAIL l0_tready: got %0b want 0", tready); end
        repeat (3) tick();
        total++; if (obs_data.size() !== 0)  begin bad++; $display("FAIL l0_count: got %0d want 0", obs_data.size()); end
        total++; if (position !== 32'd0)     begin bad++; $display("FAIL l0_position: got %0d want 0", position); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d1;
        go_idle();
        gpio = 32'h19; tvalid = 1'b1; wr_ready = 1'b1;
        repeat (3) tick();
        gpio = 32'h1B;
        tick();
        repeat (3) tick();
        wr_ready = 1'b0;
        tick();
        total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid: got %0b want 1", wr_valid); end
        areset = 1'b1;
        tick();
        total++; if (wr_valid !== 1'b0)     begin bad++; $display("FAIL rmid_wr_valid: got %0b want 0", wr_valid); end
        total++; if (wr_addr !== BASE)      begin bad++; $display("FAIL rmid_wr_addr: got %h want %h", wr_addr, BASE); end
        total++; if (wr_data !== 32'd0)     begin bad++; $display("FAIL rmid_wr_data: got %h want 0", wr_data); end
        total++; if (position !== 32'd0)    begin bad++; $display("FAIL rmid_position: got %0d want 0", position); end
        total++; if (done !== 1'b0)         begin bad++; $display("FAIL rmid_done: got %0b want 0", done); end
        total++; if (tready !== 1'b0)       begin bad++; $display("FAIL rmid_tready: got %0b want 0", tready); end
        total++; if (overrun_cnt !== 16'd0) begin bad++; $display("FAIL rmid_overrun: got %0d want 0", overrun_cnt); end
        areset = 1'b0;
        obs_addr.delete(); obs_data.delete();
        d1 = tdata;
        tick();
        wr_ready = 1'b1;
        repeat (40) tick();
        total++; if (done !== 1'b0)          begin bad++; $display("FAIL rmid_run_done: got %0b want 0", done); end
        total++; if (obs_data.size() !== 39) begin bad++; $display("FAIL rmid_count: got %0d want 39", obs_data.size()); end
        for (int k = 0; k < obs_data.size(); k++) begin
            total++; if (obs_addr[k] !== BASE + 32'(k * 4)) begin bad++; $display("FAIL rmid_addr[%0d]: got %h want %h", k, obs_addr[k], BASE + 32'(k * 4)); end
            total++; if (obs_data[k] !== d1 + 32'(k))      begin bad++; $display("FAIL rmid_data[%0d]: got %h want %h", k, obs_data[k], d1 + 32'(k)); end
        end
    endtask

    task automatic test_random();
        logic [31:0] d0;
        int l, t, n, exp_n;
        for (int it = 0; it < 3; it++) begin
            go_idle();
            l = $urandom_range(2, 4);
            t = $urandom_range(0, 2);
            tdata = $urandom;
            d0 = tdata;
            gpio = 32'h1 | (32'(l) << 2) | (32'(t) << 7);
            for (int c = 0; c < 400; c++) begin
                tvalid   = ($urandom_range(0, 3) != 0);
                wr_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            tvalid = 1'b0; wr_ready = 1'b1;
            repeat (4) tick();
            n = obs_data.size();
            exp_n = (acc_count + (1 << t) - 1) >> t;
            total++; if (n !== exp_n) begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d", it, n, exp_n); end
            for (int k = 0; k < n; k++) begin
                total++; if (obs_data[k] !== d0 + (32'(k) << t)) begin bad++; $display("FAIL rnd%0d_data[%0d]: got %h want %h", it, k, obs_data[k], d0 + (32'(k) << t)); end
                total++; if (obs_addr[k] !== BASE + 32'((k % (1 << l)) * 4)) begin bad++; $display("FAIL rnd%0d_addr[%0d]: got %h want %h", it, k, obs_addr[k], BASE + 32'((k % (1 << l)) * 4)); end
            end
            total++; if (position !== 32'(n % (1 << l))) begin bad++; $display("FAIL rnd%0d_position: got %0d want %0d", it, position, n % (1 << l)); end
        end
    endtask

    initial begin
        areset = 1'b1; gpio = 32'd0; tvalid = 1'b0; tdata = $urandom; wr_ready = 1'b1;
        @(negedge aclk);
        test_reset();
        test_back_to_back();
        test_throttle();
        test_post_hold();
        test_stall();
        test_drain();
        test_clamp();
        test_log_zero();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
